// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue unit and its neighbours.
//   DATA_W   : datapath width
//   OPC_W    : opcode width
//   alu_op_e : legal ALU operations (OP_ADD..OP_SHR)
//   OP_LAST  : highest legal opcode; anything above is illegal
//   is_legal : helper returning 1 for a legal opcode
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_NOT = 5'd4,
        OP_SHL = 5'd5,
        OP_SHR = 5'd6
    } alu_op_e;

    localparam logic [OPC_W-1:0] OP_LAST = OP_SHR;

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// ---------------------------------------------------------------------------
// alu_issue_unit_if
// Instruction channel into the ALU issue unit (valid/ready handshake).
//   in_valid   : instruction present           (master -> slave)
//   in_ready   : unit accepts this cycle        (slave  -> master)
//   in_opcode  : ALU opcode
//   in_rd      : destination register
//   in_rs1     : source register for operand a
//   in_rs2     : source register for operand b (when in_use_imm = 0)
//   in_use_imm : operand b taken from in_imm
//   in_imm     : immediate operand
// ---------------------------------------------------------------------------
interface alu_issue_unit_if
    import alu_pkg::*;
#(
    parameter int RIDX_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [RIDX_W-1:0] in_rd;
    logic [RIDX_W-1:0] in_rs1;
    logic [RIDX_W-1:0] in_rs2;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREGS x DATA_W register file. Entry 0 always reads zero and ignores writes.
//   clk, rst     : clock, asynchronous active-high clear of every entry
//   raddr1_i/rdata1_o : combinational read port for operand a
//   raddr2_i/rdata2_o : combinational read port for operand b
//   dbg_addr_i/dbg_data_o : combinational debug read port
//   we_i, waddr_i, wdata_i : synchronous write port
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [RIDX_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [RIDX_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Entry 0 is cleared by reset and never written, so it holds zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Three identical read ports; address 0 is forced to zero explicitly.
    logic [RIDX_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdata [3];

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;
    assign raddr[2] = dbg_addr_i;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rport
            assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs_q[raddr[gi]];
        end
    endgenerate

    assign rdata1_o   = rdata[0];
    assign rdata2_o   = rdata[1];
    assign dbg_data_o = rdata[2];

endmodule

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
// Execute-stage front end for a combinational ALU. Accepts instructions on
// in_if, reads operands (regfile, immediate, or forwarded ALU result), drives
// registered a/b/opcode to the ALU and retires the result one cycle later.
//   clk, rst            : clock, asynchronous active-high reset
//   in_if (slave)       : instruction channel, in_ready = !stall
//   stall               : freeze request from downstream
//   alu_a/alu_b/alu_opcode : registered ALU inputs
//   alu_result/alu_zero/alu_negative : combinational ALU outputs
//   wb_valid/wb_rd/wb_data : one-cycle writeback pulse
//   flag_zero/flag_negative : flags of the last retired legal op
//   illegal_op          : sticky, an opcode above OP_LAST was retired
//   retired_count       : wrapping count of retired instructions
//   dbg_addr/dbg_data   : combinational regfile debug read
// ---------------------------------------------------------------------------
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_unit_if.slave    in_if,
    input  logic               stall,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OPC_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_negative,
    output logic               wb_valid,
    output logic [RIDX_W-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               flag_zero,
    output logic               flag_negative,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired_count,
    input  logic [RIDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    // Stage S0 and retire-side state
    logic              stage_valid_q, stage_valid_d;
    logic [RIDX_W-1:0] stage_rd_q,    stage_rd_d;
    logic [DATA_W-1:0] alu_a_q,       alu_a_d;
    logic [DATA_W-1:0] alu_b_q,       alu_b_d;
    logic [OPC_W-1:0]  alu_opcode_q,  alu_opcode_d;
    logic              wb_valid_q,    wb_valid_d;
    logic [RIDX_W-1:0] wb_rd_q,       wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,     wb_data_d;
    logic              flag_zero_q,   flag_zero_d;
    logic              flag_neg_q,    flag_neg_d;
    logic              illegal_q,     illegal_d;
    logic [CNT_W-1:0]  retired_q,     retired_d;

    logic              accept;
    logic              retire;
    logic              stage_legal;
    logic              fwd_ok;
    logic              rf_we;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    assign in_if.in_ready = ~stall;
    assign accept         = in_if.in_valid & ~stall;
    assign retire         = stage_valid_q & ~stall;
    assign stage_legal    = is_legal(alu_opcode_q);
    assign rf_we          = retire & stage_legal;

    // The instruction in S0 writes alu_result at the same edge that the new
    // one is accepted, so its result must bypass the regfile. Illegal ops and
    // r0 destinations never write, hence they never forward.
    assign fwd_ok = stage_valid_q & stage_legal & (stage_rd_q != '0);

    alu_regfile #(
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .raddr1_i   (in_if.in_rs1),
        .rdata1_o   (rs1_data),
        .raddr2_i   (in_if.in_rs2),
        .rdata2_o   (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .waddr_i    (stage_rd_q),
        .wdata_i    (alu_result)
    );

    always_comb begin
        opa = rs1_data;
        opb = rs2_data;
        if (fwd_ok && (in_if.in_rs1 == stage_rd_q)) begin
            opa = alu_result;
        end
        if (in_if.in_use_imm) begin
            opb = in_if.in_imm;
        end else if (fwd_ok && (in_if.in_rs2 == stage_rd_q)) begin
            opb = alu_result;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_rd_d    = stage_rd_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opcode_d  = alu_opcode_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        flag_zero_d   = flag_zero_q;
        flag_neg_d    = flag_neg_q;
        illegal_d     = illegal_q;
        retired_d     = retired_q;

        // Operand registers only move on accept so the ALU inputs stay put
        // while stalled or idle.
        if (accept) begin
            stage_valid_d = 1'b1;
            stage_rd_d    = in_if.in_rd;
            alu_a_d       = opa;
            alu_b_d       = opb;
            alu_opcode_d  = in_if.in_opcode;
        end else if (retire) begin
            stage_valid_d = 1'b0;
        end

        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            if (stage_legal) begin
                wb_valid_d  = 1'b1;
                wb_rd_d     = stage_rd_q;
                wb_data_d   = alu_result;
                flag_zero_d = alu_zero;
                flag_neg_d  = alu_negative;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_rd_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            flag_zero_q   <= 1'b0;
            flag_neg_q    <= 1'b0;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_rd_q    <= stage_rd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opcode_q  <= alu_opcode_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            flag_zero_q   <= flag_zero_d;
            flag_neg_q    <= flag_neg_d;
            illegal_q     <= illegal_d;
            retired_q     <= retired_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_opcode    = alu_opcode_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign flag_zero     = flag_zero_q;
    assign flag_negative = flag_neg_q;
    assign illegal_op    = illegal_q;
    assign retired_count = retired_q;

endmodule
